// File: rtl/lfsr_gen.sv
// Fibonacci LFSR word generator with seed load, run/stop FSM, lock-up seed substitution and period measurement.
// Latency: one cycle from an accepted word to the next word; out_data holds while out_valid=1 and out_ready=0.
// Build option LFSR_XNOR_EN selects XNOR feedback, which makes all ones the lock-up value instead of all zeros.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bit,
    output logic             period_done,
    output logic [31:0]      period_len,
    output logic             lockup
);

    typedef enum logic {IDLE, RUN} fsm_e;

`ifdef LFSR_XNOR_EN
    localparam logic [WIDTH-1:0] LOCK_VAL = '1;
`else
    localparam logic [WIDTH-1:0] LOCK_VAL = '0;
`endif

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      plen_q, plen_d;
    logic             pd_q, pd_d;
    logic             lk_q, lk_d;

    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_sel;
    logic             seed_illegal;
    logic             xfer;

    always_comb begin
`ifdef LFSR_XNOR_EN
        fb = ~^(state_q & TAPS);
`else
        fb = ^(state_q & TAPS);
`endif
        next_state   = {state_q[WIDTH-2:0], fb};
        seed_illegal = (seed_in == LOCK_VAL);
        seed_sel     = seed_illegal ? SEED : seed_in;
        xfer         = out_valid & out_ready;
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        plen_d  = plen_q;
        pd_d    = 1'b0;
        lk_d    = 1'b0;
        if (load) begin
            // Load wins over a concurrent en rise: the FSM parks in IDLE.
            fsm_d   = IDLE;
            state_d = seed_sel;
            seed_d  = seed_sel;
            cnt_d   = '0;
            lk_d    = seed_illegal;
        end else begin
            case (fsm_q)
                IDLE:    if (en)  fsm_d = RUN;
                RUN:     if (!en) fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
            if (xfer) begin
                state_d = next_state;
                if (next_state == seed_q) begin
                    pd_d   = 1'b1;
                    plen_d = cnt_q + 32'd1;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= SEED;
            seed_q  <= SEED;
            cnt_q   <= '0;
            plen_q  <= '0;
            pd_q    <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
            pd_q    <= pd_d;
            lk_q    <= lk_d;
        end
    end

    assign out_valid   = (fsm_q == RUN) & ~load;
    assign out_data    = state_q;
    assign out_bit     = state_q[WIDTH-1];
    assign period_done = pd_q;
    assign period_len  = plen_q;
    assign lockup      = lk_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen at WIDTH=4, TAPS=4'hC, SEED=4'h1: directed scenarios followed by random traffic,
// all checked against a word-level reference model.
module tb_lfsr_gen;

    localparam int         W      = 4;
    localparam logic [3:0] TAPS_P = 4'hC;
    localparam logic [3:0] SEED_P = 4'h1;
`ifdef LFSR_XNOR_EN
    localparam logic [3:0] LOCK_P = 4'hF;
`else
    localparam logic [3:0] LOCK_P = 4'h0;
`endif

    logic        clk;
    logic        rst;
    logic        load;
    logic [3:0]  seed_in;
    logic        en;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_bit;
    logic        period_done;
    logic [31:0] period_len;
    logic        lockup;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  m_state;
    logic [3:0]  m_seed;
    logic [31:0] m_cnt;
    logic [31:0] m_plen;
    bit          m_run;
    bit          m_pd;
    bit          m_lk;

    lfsr_gen #(.WIDTH(W), .TAPS(TAPS_P), .SEED(SEED_P)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .seed_in    (seed_in),
        .en         (en),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_bit    (out_bit),
        .period_done(period_done),
        .period_len (period_len),
        .lockup     (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next word: shift left by one (multiply by two modulo 16) and append the tap parity.
    function automatic logic [3:0] ref_next(input logic [3:0] st);
        int ones = $countones(st & TAPS_P);
        int fb   = ones % 2;
        int s    = int'(st);
`ifdef LFSR_XNOR_EN
        fb = 1 - fb;
`endif
        return 4'((s * 2 + fb) % 16);
    endfunction

    task automatic model_reset();
        m_state = SEED_P;
        m_seed  = SEED_P;
        m_cnt   = 0;
        m_plen  = 0;
        m_run   = 0;
        m_pd    = 0;
        m_lk    = 0;
    endtask

    // Apply inputs for this cycle and compare every output with the model.
    task automatic drive(input bit r_rst, input bit l, input logic [3:0] s, input bit e, input bit r);
        rst       = r_rst;
        load      = l;
        seed_in   = s;
        en        = e;
        out_ready = r;
        #1;
        chk("out_valid",   32'(out_valid),   32'(m_run && !l));
        chk("out_data",    32'(out_data),    32'(m_state));
        chk("out_bit",     32'(out_bit),     32'(m_state[3]));
        chk("period_done", 32'(period_done), 32'(m_pd));
        chk("period_len",  period_len,       m_plen);
        chk("lockup",      32'(lockup),      32'(m_lk));
    endtask

    // Advance the model across the coming edge, then move to the next falling edge.
    task automatic tick();
        logic [3:0] nxt;
        if (rst) begin
            model_reset();
        end else if (load) begin
            m_lk    = (seed_in == LOCK_P);
            m_state = m_lk ? SEED_P : seed_in;
            m_seed  = m_state;
            m_cnt   = 0;
            m_run   = 0;
            m_pd    = 0;
        end else begin
            m_lk = 0;
            m_pd = 0;
            if (m_run && out_ready) begin
                nxt   = ref_next(m_state);
                m_cnt = m_cnt + 1;
                if (nxt == m_seed) begin
                    m_pd   = 1;
                    m_plen = m_cnt;
                    m_cnt  = 0;
                end
                m_state = nxt;
            end
            m_run = en;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] seq1 [16];

    initial begin
        seq1 = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        rst = 1'b1; load = 1'b0; seed_in = '0; en = 1'b0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset state, then en rises: first cycle still IDLE.
        drive(0, 0, 4'h0, 1, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'(SEED_P));
        tick();

        // Full period from the reset seed.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 4'h0, 1, 1);
`ifndef LFSR_XNOR_EN
            chk("p1_seq", 32'(out_data), 32'(seq1[i]));
`endif
            chk("p1_pd", 32'(period_done), 32'(i == 15));
            if (i == 15) chk("p1_plen", period_len, 32'd15);
            tick();
        end

        // Backpressure: stall at 9.
        for (int k = 0; k < 20 && m_state != 4'h9; k++) begin
            drive(0, 0, 4'h0, 1, 1);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 4'h0, 1, 0);
            chk("p2_hold_vld", 32'(out_valid), 32'd1);
`ifndef LFSR_XNOR_EN
            chk("p2_hold_dat", 32'(out_data), 32'h9);
`endif
            tick();
        end
        drive(0, 0, 4'h0, 1, 1);
        tick();
        drive(0, 0, 4'h0, 1, 1);
`ifndef LFSR_XNOR_EN
        chk("p2_after", 32'(out_data), 32'h3);
`endif
        tick();

        // Lock-up seed with en high: no transfer in the load cycle.
        drive(0, 1, LOCK_P, 1, 1);
        chk("p3_load_vld", 32'(out_valid), 32'd0);
        tick();
        drive(0, 0, 4'h0, 0, 1);
        chk("p3_lockup", 32'(lockup),    32'd1);
        chk("p3_data",   32'(out_data),  32'(SEED_P));
        chk("p3_vld",    32'(out_valid), 32'd0);
        tick();
        drive(0, 0, 4'h0, 0, 1);
        chk("p3_lk_clr", 32'(lockup), 32'd0);
        tick();

        // Seed A, full period back to A.
        drive(0, 1, 4'hA, 1, 1);
        tick();
        drive(0, 0, 4'h0, 1, 1);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 4'h0, 1, 1);
`ifndef LFSR_XNOR_EN
            if (i == 1) chk("p4_first", 32'(out_data), 32'h5);
            if (i == 2) chk("p4_second", 32'(out_data), 32'hB);
`endif
            chk("p4_pd", 32'(period_done), 32'(i == 15));
            if (i == 15) begin
                chk("p4_data", 32'(out_data), 32'hA);
                chk("p4_plen", period_len, 32'd15);
            end
            tick();
        end

        // Reset mid-run at 6.
        for (int k = 0; k < 20 && m_state != 4'h6; k++) begin
            drive(0, 0, 4'h0, 1, 1);
            tick();
        end
        drive(1, 0, 4'h0, 1, 1);
        tick();
        drive(0, 0, 4'h0, 1, 1);
        chk("p5_data", 32'(out_data),  32'h1);
        chk("p5_vld",  32'(out_valid), 32'd0);
        chk("p5_plen", period_len,     32'd0);
        tick();
        drive(0, 0, 4'h0, 1, 1);
        chk("p5_resume_vld", 32'(out_valid), 32'd1);
        tick();
        drive(0, 0, 4'h0, 1, 1);
`ifndef LFSR_XNOR_EN
        chk("p5_resume_dat", 32'(out_data), 32'h2);
`endif
        tick();

`ifdef LFSR_XNOR_EN
        // All-ones seed is the lock-up value under XNOR feedback.
        drive(0, 1, 4'hF, 0, 1);
        tick();
        drive(0, 0, 4'h0, 1, 1);
        chk("p6_lockup", 32'(lockup),   32'd1);
        chk("p6_data",   32'(out_data), 32'(SEED_P));
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 4'h0, 1, 1);
            chk("p6_pd", 32'(period_done), 32'(i == 15));
            if (i == 15) chk("p6_plen", period_len, 32'd15);
            tick();
        end
`endif

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            bit         r_rst, l, e, r;
            logic [3:0] s;
            r_rst = ($urandom_range(0, 79) == 0);
            l     = ($urandom_range(0, 19) == 0);
            s     = ($urandom_range(0, 2) == 0) ? LOCK_P : 4'($urandom_range(0, 15));
            e     = ($urandom_range(0, 7) != 0);
            r     = ($urandom_range(0, 3) != 0);
            drive(r_rst, l, s, e, r);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
